array_be_sync_ram: RTL

Parametrised single-clock simple-dual-port RAM: one write port with per-byte enables, one read port with a read handshake. It adds selectable read-during-write behaviour, an optional output pipeline stage and a post-reset clear sequencer. It is the next-generation storage primitive after array_behavioral_simple, used wherever a datapath needs a small register-file or buffer with partial-word writes and known contents after reset.

---
 rtl/array_be_sync_ram_if.sv | 29 ++
 rtl/array_be_sync_ram.sv | 132 +++++++++++++
 2 files changed

// File: rtl/array_be_sync_ram_if.sv
// array_be_sync_ram_if: request/response bundle for array_be_sync_ram.
// master drives the write port (write_en/addr/data/be) and the read request
// (read_en/read_addr); slave (the RAM) returns read_data, read_valid and init_busy.
interface array_be_sync_ram_if #(
    parameter int WIDTH = 32,
    parameter int ADDR  = 4
);
    localparam int BYTES = WIDTH / 8;

    logic             write_en;
    logic [ADDR-1:0]  write_addr;
    logic [WIDTH-1:0] write_data;
    logic [BYTES-1:0] write_be;
    logic             read_en;
    logic [ADDR-1:0]  read_addr;
    logic [WIDTH-1:0] read_data;
    logic             read_valid;
    logic             init_busy;

    modport master (
        output write_en, write_addr, write_data, write_be, read_en, read_addr,
        input  read_data, read_valid, init_busy
    );

    modport slave (
        input  write_en, write_addr, write_data, write_be, read_en, read_addr,
        output read_data, read_valid, init_busy
    );
endinterface

// File: rtl/array_be_sync_ram.sv
// array_be_sync_ram: simple-dual-port RAM with byte-enable writes, selectable
// read-during-write behaviour, optional output register and post-reset clear.
// Ports:
//   clk  - single clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - slave side of array_be_sync_ram_if:
//          write_en/write_addr/write_data/write_be in, read_en/read_addr in,
//          read_data/read_valid/init_busy out
module array_be_sync_ram #(
    parameter int WIDTH        = 32,
    parameter int DEPTH        = 16,
    parameter int ADDR         = 4,
    parameter int RD_PIPE      = 0,
    parameter int RDW_MODE     = 0,
    parameter int CLEAR_ON_RST = 1
) (
    input logic               clk,
    input logic               rst,
    array_be_sync_ram_if.slave bus
);
    localparam int BYTES = WIDTH / 8;

    typedef enum logic {CLEAR, READY} state_t;

    state_t           state_q, state_d;
    logic [ADDR-1:0]  cnt_q, cnt_d;
    logic             busy;
    logic             last;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             wr_acc, rd_acc;
    logic             wr_in, rd_in;
    logic             rdw_hit;
    logic [WIDTH-1:0] old_word, merged, rd_word;
    logic             s1_valid_q;
    logic [WIDTH-1:0] s1_data_q;
    logic             rd_valid;
    logic [WIDTH-1:0] rd_data;

    // Clear sequencer: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= (CLEAR_ON_RST != 0) ? CLEAR : READY;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign last = (cnt_q == ADDR'(DEPTH - 1));

    // Clear sequencer: next state
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == CLEAR) begin
            cnt_d   = last ? '0 : cnt_q + 1'b1;
            state_d = last ? READY : CLEAR;
        end
    end

    // Clear sequencer: outputs
    always_comb begin
        busy = (state_q == CLEAR);
    end

    // Requests seen during reset are dropped so nothing leaks past the reset edge.
    assign wr_acc = bus.write_en && !busy && !rst;
    assign rd_acc = bus.read_en && !busy && !rst;

    // Zero-extended compare keeps this correct for non-power-of-two depths.
    assign wr_in = ({1'b0, bus.write_addr} < (ADDR + 1)'(DEPTH));
    assign rd_in = ({1'b0, bus.read_addr} < (ADDR + 1)'(DEPTH));

    assign old_word = rd_in ? mem[bus.read_addr] : '0;

    always_comb begin
        merged = old_word;
        for (int k = 0; k < BYTES; k++)
            if (bus.write_be[k]) merged[8*k +: 8] = bus.write_data[8*k +: 8];
    end

    // Write-first forwarding for a same-address collision.
    assign rdw_hit = (RDW_MODE != 0) && wr_acc && wr_in && rd_in
                     && (bus.write_addr == bus.read_addr);
    assign rd_word = rdw_hit ? merged : old_word;

    // Storage array: never reset; zeroed by the sequencer instead.
    always_ff @(posedge clk) begin
        if (busy && !rst)
            mem[cnt_q] <= '0;
        else if (wr_acc && wr_in)
            for (int k = 0; k < BYTES; k++)
                if (bus.write_be[k]) mem[bus.write_addr][8*k +: 8] <= bus.write_data[8*k +: 8];
    end

    // First read stage: sampled word, held between reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
        end else begin
            s1_valid_q <= rd_acc;
            if (rd_acc) s1_data_q <= rd_word;
        end
    end

    generate
        if (RD_PIPE != 0) begin : g_pipe
            logic             out_valid_q;
            logic [WIDTH-1:0] out_data_q;
            always_ff @(posedge clk) begin
                if (rst) begin
                    out_valid_q <= 1'b0;
                    out_data_q  <= '0;
                end else begin
                    out_valid_q <= s1_valid_q;
                    if (s1_valid_q) out_data_q <= s1_data_q;
                end
            end
            assign rd_valid = out_valid_q;
            assign rd_data  = out_data_q;
        end else begin : g_nopipe
            assign rd_valid = s1_valid_q;
            assign rd_data  = s1_data_q;
        end
    endgenerate

    assign bus.read_data  = rd_data;
    assign bus.read_valid = rd_valid;
    assign bus.init_busy  = busy;
endmodule
